// File: rtl/capture_frame_ctrl.sv
// Capture sequencer: packetizes a free-running sample stream into AXI-Stream frames of
// programmed length/count through a small show-ahead FIFO, counting overflow drops.
module capture_frame_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [LEN_W-1:0]      cfg_frame_len,
  input  logic [15:0]           cfg_frame_cnt,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic [DATA_W-1:0]     m_tdata,
  output logic [DATA_W/8-1:0]   m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frames_done,
  output logic [15:0]           ovf_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [15:0]       frames_q, frames_d;
  logic [15:0]       ovf_q, ovf_d;
  logic              stop_pend_q, stop_pend_d;
  logic [AW:0]       wptr_q, rptr_q;
  logic [AW:0]       fifo_count;
  logic              fifo_full, fifo_empty;
  logic              push, pop, drop;
  logic              stop_eff, last_beat, cnt_reached;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [DATA_W:0]   head;

  // FIFO bookkeeping: pointers carry one extra wrap bit so full/empty are unambiguous
  assign fifo_count = wptr_q - rptr_q;
  assign fifo_full  = (fifo_count == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (wptr_q == rptr_q);
  assign head       = mem[rptr_q[AW-1:0]];

  assign m_tvalid = ~fifo_empty;
  assign m_tdata  = m_tvalid ? head[DATA_W-1:0] : '0;
  assign m_tlast  = m_tvalid & head[DATA_W];
  assign m_tkeep  = '1;
  assign pop      = m_tvalid & m_tready;

  assign busy        = (state_q == StRun) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign frames_done = frames_q;
  assign ovf_cnt     = ovf_q;

  assign stop_eff    = cfg_stop | stop_pend_q;
  assign last_beat   = (beat_q == len_q - LEN_W'(1));
  assign cnt_reached = (cnt_q != 16'd0) && (({1'b0, frames_q} + 17'd1) == {1'b0, cnt_q});

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    frames_d    = frames_q;
    ovf_d       = ovf_q;
    stop_pend_d = stop_pend_q;
    push        = 1'b0;
    drop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_start && (cfg_frame_len != '0)) begin
          len_d       = cfg_frame_len;
          cnt_d       = cfg_frame_cnt;
          beat_d      = '0;
          frames_d    = 16'd0;
          ovf_d       = 16'd0;
          stop_pend_d = 1'b0;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (stop_eff && (beat_q == '0)) begin
          // At a frame boundary a stop wins over any sample, so no new frame is begun.
          stop_pend_d = 1'b0;
          state_d     = StDrain;
        end else begin
          if (cfg_stop) stop_pend_d = 1'b1;
          if (in_valid) begin
            if (!fifo_full || pop) push = 1'b1;
            else                   drop = 1'b1;
          end
          if (push) begin
            if (last_beat) begin
              beat_d = '0;
              if (frames_q != 16'hFFFF) frames_d = frames_q + 16'd1;
              if (stop_eff || cnt_reached) begin
                stop_pend_d = 1'b0;
                state_d     = StDrain;
              end
            end else begin
              beat_d = beat_q + LEN_W'(1);
            end
          end
          if (drop && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
        end
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= 16'd0;
      beat_q      <= '0;
      frames_q    <= 16'd0;
      ovf_q       <= 16'd0;
      stop_pend_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      frames_q    <= frames_d;
      ovf_q       <= ovf_d;
      stop_pend_q <= stop_pend_d;
      if (push) wptr_q <= wptr_q + (AW + 1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= {last_beat, in_data};
  end

endmodule

// File: tb/tb_capture_frame_ctrl.sv
// Directed bench for capture_frame_ctrl: a table of capture scenarios with hand-computed
// beat streams and counters, plus hand-written sequences for ignored starts and reset.
module tb_capture_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [15:0] cfg_frame_len = 16'd0;
  logic [15:0] cfg_frame_cnt = 16'd0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] frames_done;
  logic [15:0] ovf_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  capture_frame_ctrl #(
    .DATA_W    (32),
    .LEN_W     (16),
    .FIFO_DEPTH(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .cfg_frame_len(cfg_frame_len),
    .cfg_frame_cnt(cfg_frame_cnt),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tlast      (m_tlast),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .busy         (busy),
    .done         (done),
    .frames_done  (frames_done),
    .ovf_cnt      (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int cnt;
    bit rand_rdy;
    int ready_low;   // tready held low for RUN cycles 1..ready_low
    int stop_at;     // RUN cycle carrying cfg_stop (0 = none)
    int restart_at;  // RUN cycle carrying a stray cfg_start (0 = none)
    int base;        // ramp value presented in RUN cycle 1
    int skip_at;     // beat index from which skip_n ramp values were dropped
    int skip_n;
    int exp_beats;
    int exp_frames;
    int exp_ovf;
    int done_k;      // RUN cycle in which done is seen (0 = not checked)
  } row_t;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic run_row(input row_t r, input int id);
    int    nbeats = 0;
    int    ndone = 0;
    int    done_at = 0;
    bit    seen_done = 1'b0;
    bit    rdy;
    logic  pv = 1'b0, pl = 1'b0, prdy = 1'b0;
    logic [31:0] pd = 32'd0;
    logic [31:0] exp_d;
    @(negedge clk);
    cfg_frame_len = 16'(r.len);
    cfg_frame_cnt = 16'(r.cnt);
    cfg_start     = 1'b1;
    in_valid      = 1'b0;
    m_tready      = 1'b0;
    for (int k = 1; k <= 200 && !seen_done; k++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
      if (done) begin
        ndone++;
        seen_done = 1'b1;
        done_at   = k;
        check($sformatf("r%0d busy_in_done", id), 32'(busy), 32'd0);
      end
      if (k == 1) check($sformatf("r%0d busy_rise", id), 32'(busy), 32'd1);
      if (k == 2) check($sformatf("r%0d first_valid", id), 32'(m_tvalid), 32'd1);
      if (pv && !prdy) begin
        check($sformatf("r%0d hold_valid k%0d", id, k), 32'(m_tvalid), 32'd1);
        check($sformatf("r%0d hold_data k%0d", id, k), m_tdata, pd);
        check($sformatf("r%0d hold_last k%0d", id, k), 32'(m_tlast), 32'(pl));
      end
      rdy = r.rand_rdy ? 1'($urandom_range(0, 1)) : (k > r.ready_low);
      m_tready = rdy;
      if (m_tvalid && rdy) begin
        exp_d = 32'(r.base + nbeats + ((nbeats >= r.skip_at) ? r.skip_n : 0));
        check($sformatf("r%0d beat%0d data", id, nbeats), m_tdata, exp_d);
        check($sformatf("r%0d beat%0d last", id, nbeats), 32'(m_tlast),
              32'((nbeats % r.len) == r.len - 1));
        nbeats++;
      end
      pv = m_tvalid;
      pd = m_tdata;
      pl = m_tlast;
      prdy = rdy;
      in_valid = 1'b1;
      in_data  = 32'(r.base + k - 1);
      if (k == r.stop_at) cfg_stop = 1'b1;
      if (k == r.restart_at) begin
        cfg_start     = 1'b1;
        cfg_frame_len = 16'd7;
      end
    end
    check($sformatf("r%0d done_seen", id), 32'(seen_done), 32'd1);
    if (r.done_k != 0) check($sformatf("r%0d done_cycle", id), 32'(done_at), 32'(r.done_k));
    // Trailing idle cycles: no further beats, no second done pulse.
    m_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (m_tvalid) nbeats++;
      in_data = in_data + 32'd1;
    end
    in_valid = 1'b0;
    check($sformatf("r%0d beats", id), 32'(nbeats), 32'(r.exp_beats));
    check($sformatf("r%0d done_pulses", id), 32'(ndone), 32'd1);
    check($sformatf("r%0d busy_after", id), 32'(busy), 32'd0);
    check($sformatf("r%0d frames_done", id), 32'(frames_done), 32'(r.exp_frames));
    check($sformatf("r%0d ovf_cnt", id), 32'(ovf_cnt), 32'(r.exp_ovf));
    check($sformatf("r%0d tkeep", id), 32'(m_tkeep), 32'hF);
  endtask

  row_t rows[7];
  row_t r;

  initial begin
    //        len cnt rnd rlow stop rst  base  skip@ n  beats fr ovf done_k
    rows[0] = '{4,  2,  0, 0,   0,   0,   0,    99,  0, 8,    2, 0,  11};
    rows[1] = '{8,  4,  0, 20,  0,   0,   0,    16,  4, 32,   4, 4,  54};
    rows[2] = '{10, 0,  0, 0,   14,  0,   1000, 99,  0, 20,   2, 0,  23};
    rows[3] = '{4,  0,  0, 0,   9,   0,   2000, 99,  0, 8,    2, 0,  11};
    rows[4] = '{4,  2,  0, 0,   0,   3,   3000, 99,  0, 8,    2, 0,  11};
    rows[5] = '{3,  5,  1, 0,   0,   0,   4000, 99,  0, 15,   5, 0,  0};
    rows[6] = '{1,  3,  0, 0,   0,   0,   5000, 99,  0, 3,    3, 0,  6};

    repeat (3) @(negedge clk);
    check("reset tvalid", 32'(m_tvalid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frames", 32'(frames_done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_row(rows[i], i);

    // len=0 start is ignored; counters from the last capture are held.
    @(negedge clk);
    cfg_frame_len = 16'd0;
    cfg_frame_cnt = 16'd2;
    cfg_start     = 1'b1;
    in_valid      = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (4) @(negedge clk);
    check("len0 busy", 32'(busy), 32'd0);
    check("len0 tvalid", 32'(m_tvalid), 32'd0);
    check("len0 frames_held", 32'(frames_done), 32'd3);
    in_valid = 1'b0;

    // Async reset with five entries queued (tready held low).
    @(negedge clk);
    cfg_frame_len = 16'd2;
    cfg_frame_cnt = 16'd0;
    cfg_start     = 1'b1;
    m_tready      = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'(100 + k - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst frames", 32'(frames_done), 32'd2);
    check("pre_rst tvalid", 32'(m_tvalid), 32'd1);
    check("pre_rst tdata", m_tdata, 32'd100);
    #1 rst = 1'b1;
    #1;
    check("rst tvalid", 32'(m_tvalid), 32'd0);
    check("rst tlast", 32'(m_tlast), 32'd0);
    check("rst tdata", m_tdata, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst frames", 32'(frames_done), 32'd0);
    check("rst ovf", 32'(ovf_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    r = rows[0];
    r.base = 500;
    run_row(r, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_frame_ctrl.md
# capture_frame_ctrl

Capture sequencer between the free-running FIR testbench outputs and the DMA S2MM sink streams. Packetizes the untimed `data_out`/`testvec` sample stream into AXI-Stream frames of software-programmed length and count, with correct `tlast` and real `tready` backpressure. It buffers samples in a small FIFO and counts samples dropped on overflow. It replaces the constant `tvalid=1`/`tlast=0` tie-offs on the sink ports.

## Interface
Parameters:
- `DATA_W`, 32: sample and `m_tdata` width.
- `LEN_W`, 16: width of the frame-length field.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of 2, at least 4.

Ports:
- `clk`, in, 1: single clock (the `tb_clk` domain).
- `rst`, in, 1: asynchronous, active-high reset.
- `cfg_start`, in, 1: one-cycle start pulse.
- `cfg_stop`, in, 1: one-cycle stop pulse, honoured at the next frame boundary.
- `cfg_frame_len`, in, LEN_W: beats per frame; 0 is illegal and the start is ignored.
- `cfg_frame_cnt`, in, 16: frames to capture; 0 means continuous until stop.
- `in_data`, in, DATA_W: DUT sample.
- `in_valid`, in, 1: sample strobe; no ready is returned and the source never stalls.
- `m_tdata`, out, DATA_W: AXI-Stream master data.
- `m_tkeep`, out, DATA_W/8: constant all-ones.
- `m_tlast`, out, 1: last beat of a frame.
- `m_tvalid`, out, 1: master valid.
- `m_tready`, in, 1: master ready from the S2MM.
- `busy`, out, 1: high in RUN or DRAIN.
- `done`, out, 1: one-cycle pulse when capture completes.
- `frames_done`, out, 16: frames fully pushed into the FIFO; saturating.
- `ovf_cnt`, out, 16: samples dropped because the FIFO was full; saturating at 0xFFFF.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - A `cfg_start` with `cfg_frame_len != 0` latches length and count, clears `frames_done`, `ovf_cnt` and the beat counter, and moves to RUN.
  - `cfg_start` in any other state is ignored.
- **RUN**, on each `in_valid`:
  - Push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise drop the sample and increment `ovf_cnt`.
  - The beat counter advances only on a push. The pushed entry's last flag is `(beat == len-1)`, after which the beat counter returns to 0.
  - On a push with the last flag set, `frames_done` increments.
- **RUN exit**
  - Go to DRAIN after the last beat of frame number `cfg_frame_cnt` is pushed (only when `cfg_frame_cnt != 0`).
  - `cfg_stop` sets `stop_pending`. If the beat counter is 0 with no partial frame, go to DRAIN on the next cycle. Otherwise go to DRAIN after the current frame's last beat is pushed. A partial frame is never emitted.
  - A stop and a frame-count completion in the same cycle give a single DRAIN entry.
- **DRAIN**
  - No pushes; `in_valid` samples are discarded and are not counted in `ovf_cnt`.
  - Go to DONE when the FIFO is empty and no beat is pending on the output.
- **DONE**: `done`=1 for one cycle, then IDLE. Counters hold until the next accepted start.
- **FIFO**
  - Show-ahead.
  - `m_tvalid = !empty`.
  - `m_tdata`/`m_tlast` reflect the head entry.
  - Pop on `m_tvalid & m_tready`.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Full means count == DEPTH.
- **AXI rules**
  - Once `m_tvalid` rises, `m_tdata`/`m_tlast` stay stable until the handshake.
  - `m_tvalid` never drops without a handshake.
- **Reset mid-operation**
  - Go to IDLE immediately and flush the FIFO. Any in-flight frame is lost, with no `tlast` emitted.
  - Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `busy`=0, `done`=0, `frames_done`=0, `ovf_cnt`=0.

## Timing
- Start pulse at cycle T: state is RUN at T+1, and the first eligible sample is the one with `in_valid` at T+1.
- Push at cycle T into an empty FIFO: `m_tvalid`=1 with that data at T+1. Latency is 1 cycle.
- `busy` rises at T+1 after the start and falls in the DONE cycle. `done` is asserted in that same cycle.
- With `m_tready` held at 1 and continuous `in_valid`, throughput is 1 beat per clock, with no drops and no bubbles after the first beat.
- `frames_done` updates in the cycle after the pushing edge. `ovf_cnt` updates in the cycle after the drop.

## Test plan
- **Basic frames.** len=4, cnt=2, `m_tready`=1, continuous ramp 0..: 8 beats 0..7 out; `tlast` on beats 3 and 7; `frames_done`=2; `ovf_cnt`=0; one `done` pulse; `busy` low after.
- **Backpressure overflow.** DEPTH=16, len=8, cnt=4, `m_tready`=0 for the first 20 cycles of RUN, then 1:
  - Required: first 16 samples buffered; `ovf_cnt`=4.
  - Required: 32 beats output with `tlast` every 8th beat.
  - Required: data skips exactly the 4 dropped ramp values.
- **Stop mid-frame.** len=10, cnt=0, `cfg_stop` after 13 pushes: RUN continues to 20 pushes; `tlast` on beats 9 and 19; `frames_done`=2; `done` after drain.
- **Stop on boundary and ignored starts.** Stop with beat counter 0: DRAIN next cycle, no extra beat. `cfg_start` with len=0: state stays IDLE. `cfg_start` during RUN: no counter clear.
- **Random-ready AXI check.** 50% random `m_tready`, len=3, cnt=5: `m_tdata`/`m_tlast` stable whenever `tvalid` & !`tready`; no beat lost or duplicated.
- **Async reset mid-RUN.** Assert `rst` with 5 entries queued: outputs go to their reset values without a clock; after release, a fresh start gives a clean frame sequence starting with the first new sample.
